// File: rtl/pmem_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter_n_if
// Purpose  : Bundle of requester-side and physical-memory-side signals for
//            the N-port physical-memory arbiter. The slave modport is the
//            arbiter's view; the master modport is the view of whatever
//            drives the requests and models the memory.
// Revision : 1.0  initial release
// ============================================================================
interface pmem_arbiter_n_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BLOCK_W   = 128
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Requester side
    logic [NUM_PORTS-1:0]         req_read;
    logic [NUM_PORTS-1:0]         req_write;
    logic [NUM_PORTS*ADDR_W-1:0]  req_address;
    logic [NUM_PORTS*BLOCK_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]         req_resp;
    logic [BLOCK_W-1:0]           req_rdata;

    // Physical memory side
    logic                         pmem_resp;
    logic [BLOCK_W-1:0]           pmem_rdata;
    logic                         pmem_read;
    logic                         pmem_write;
    logic [ADDR_W-1:0]            pmem_address;
    logic [BLOCK_W-1:0]           pmem_wdata;

    // Grant status
    logic                         grant_valid;
    logic [ID_W-1:0]              grant_id;

    modport slave (
        input  req_read, req_write, req_address, req_wdata,
        input  pmem_resp, pmem_rdata,
        output req_resp, req_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        output grant_valid, grant_id
    );

    modport master (
        output req_read, req_write, req_address, req_wdata,
        output pmem_resp, pmem_rdata,
        input  req_resp, req_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/pmem_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter_n
// Purpose  : N-port physical-memory arbiter. Grants one requester for a whole
//            cache-block transaction, with fixed-priority or round-robin
//            selection, followed by a one-cycle recovery slot so the finished
//            requester can drop its stale request before the next arbitration.
// Revision : 1.0  initial release
// ============================================================================
module pmem_arbiter_n #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BLOCK_W   = 128,
    parameter int RR_MODE   = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pmem_arbiter_n_if.slave  bus
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_gid;
    logic [ID_W-1:0]        w_gid_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        w_rr_ptr_nxt;

    logic [NUM_PORTS-1:0]   w_reqs;
    logic                   w_any_req;
    logic [ID_W-1:0]        w_winner;
    logic                   w_found;
    logic [ID_W:0]          w_sum;
    logic [ID_W-1:0]        w_idx;

    logic [NUM_PORTS-1:0]   w_gid_oh;
    logic                   w_sel_rd;
    logic                   w_sel_wr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [BLOCK_W-1:0]     w_sel_wdata;
    logic [ID_W-1:0]        w_rr_inc;

    logic                   w_pmem_read;
    logic                   w_pmem_write;
    logic [ADDR_W-1:0]      w_pmem_address;
    logic [BLOCK_W-1:0]     w_pmem_wdata;
    logic [NUM_PORTS-1:0]   w_req_resp;
    logic                   w_grant_valid;

    assign w_reqs    = bus.req_read | bus.req_write;
    assign w_any_req = |w_reqs;

    // Winner search: from port 0 in fixed mode, from rr_ptr with wrap in round-robin mode
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (ID_W+1)'(NUM_PORTS);
                end
                w_idx = w_sum[ID_W-1:0];
            end else begin
                w_idx = ID_W'(k);
            end
            if (!w_found && w_reqs[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Granted-port mux driven from the registered grant index
    always_comb begin
        w_gid_oh    = '0;
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_gid == ID_W'(i)) begin
                w_gid_oh[i] = 1'b1;
                w_sel_rd    = bus.req_read[i];
                w_sel_wr    = bus.req_write[i];
                w_sel_addr  = bus.req_address[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.req_wdata[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

    // Round-robin pointer moves past the port that just completed
    assign w_rr_inc = (r_gid == ID_W'(NUM_PORTS-1)) ? '0 : r_gid + ID_W'(1);

    // Next-state and output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_gid_nxt      = r_gid;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_pmem_read    = 1'b0;
        w_pmem_write   = 1'b0;
        w_pmem_address = '0;
        w_pmem_wdata   = '0;
        w_req_resp     = '0;
        w_grant_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_gid_nxt   = w_winner;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_grant_valid  = 1'b1;
                w_pmem_write   = w_sel_wr;
                w_pmem_read    = w_sel_rd & ~w_sel_wr;
                w_pmem_address = w_sel_addr;
                w_pmem_wdata   = w_sel_wdata;
                if (bus.pmem_resp) begin
                    w_req_resp   = w_gid_oh;
                    w_rr_ptr_nxt = w_rr_inc;
                    w_state_nxt  = S_RECOVER;
                end else if (!(w_sel_rd | w_sel_wr)) begin
                    // Requester abandoned the transaction: close it without completing
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gid    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gid    <= w_gid_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_address;
    assign bus.pmem_wdata   = w_pmem_wdata;
    assign bus.req_resp     = w_req_resp;
    assign bus.req_rdata    = reset ? '0 : bus.pmem_rdata;
    assign bus.grant_valid  = w_grant_valid;
    assign bus.grant_id     = (r_state == S_BUSY) ? r_gid : '0;
endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pmem_arbiter_n
// Purpose  : Self-checking bench for pmem_arbiter_n: a 2-port fixed-priority
//            instance, a 4-port fixed-priority instance and a 4-port
//            round-robin instance share one stimulus set; a selector picks
//            which instance's outputs are compared.
// Revision : 1.0  initial release
// ============================================================================
module tb_pmem_arbiter_n;
    localparam int AW = 16;
    localparam int BW = 128;

    localparam logic [AW-1:0] AD0 = 16'h0040;
    localparam logic [AW-1:0] AD1 = 16'h1230;
    localparam logic [AW-1:0] AD2 = 16'h2200;
    localparam logic [AW-1:0] AD3 = 16'h3300;
    localparam logic [BW-1:0] WD0 = {8{16'h1111}};
    localparam logic [BW-1:0] WD1 = {8{16'h2222}};
    localparam logic [BW-1:0] WD2 = {8{16'h3333}};
    localparam logic [BW-1:0] WD3 = {8{16'h4444}};
    localparam logic [BW-1:0] PRD = {16{8'hA5}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]      t_rd;
    logic [3:0]      t_wr;
    logic            t_presp;
    logic [4*AW-1:0] t_addr;
    logic [4*BW-1:0] t_wdata;
    logic [BW-1:0]   t_prdata;

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;

    pmem_arbiter_n_if #(.NUM_PORTS(2), .ADDR_W(AW), .BLOCK_W(BW)) if_a();
    pmem_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW)) if_f();
    pmem_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW)) if_r();

    assign if_a.req_read    = t_rd[1:0];
    assign if_a.req_write   = t_wr[1:0];
    assign if_a.req_address = t_addr[2*AW-1:0];
    assign if_a.req_wdata   = t_wdata[2*BW-1:0];
    assign if_a.pmem_resp   = t_presp;
    assign if_a.pmem_rdata  = t_prdata;

    assign if_f.req_read    = t_rd;
    assign if_f.req_write   = t_wr;
    assign if_f.req_address = t_addr;
    assign if_f.req_wdata   = t_wdata;
    assign if_f.pmem_resp   = t_presp;
    assign if_f.pmem_rdata  = t_prdata;

    assign if_r.req_read    = t_rd;
    assign if_r.req_write   = t_wr;
    assign if_r.req_address = t_addr;
    assign if_r.req_wdata   = t_wdata;
    assign if_r.pmem_resp   = t_presp;
    assign if_r.pmem_rdata  = t_prdata;

    pmem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(0)) u_a (
        .clk(clk), .reset(reset), .bus(if_a));
    pmem_arbiter_n #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(0)) u_f (
        .clk(clk), .reset(reset), .bus(if_f));
    pmem_arbiter_n #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(1)) u_r (
        .clk(clk), .reset(reset), .bus(if_r));

    // Observed outputs of the instance under test
    logic          m_rd, m_wr, m_gv;
    logic [3:0]    m_resp;
    logic [1:0]    m_gid;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_rdata;

    always_comb begin
        m_rd = 1'b0; m_wr = 1'b0; m_gv = 1'b0; m_resp = '0; m_gid = '0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        case (sel)
            0: begin
                m_rd = if_a.pmem_read; m_wr = if_a.pmem_write; m_gv = if_a.grant_valid;
                m_resp = {2'b00, if_a.req_resp}; m_gid = {1'b0, if_a.grant_id};
                m_addr = if_a.pmem_address; m_wdata = if_a.pmem_wdata; m_rdata = if_a.req_rdata;
            end
            1: begin
                m_rd = if_f.pmem_read; m_wr = if_f.pmem_write; m_gv = if_f.grant_valid;
                m_resp = if_f.req_resp; m_gid = if_f.grant_id;
                m_addr = if_f.pmem_address; m_wdata = if_f.pmem_wdata; m_rdata = if_f.req_rdata;
            end
            default: begin
                m_rd = if_r.pmem_read; m_wr = if_r.pmem_write; m_gv = if_r.grant_valid;
                m_resp = if_r.req_resp; m_gid = if_r.grant_id;
                m_addr = if_r.pmem_address; m_wdata = if_r.pmem_wdata; m_rdata = if_r.req_rdata;
            end
        endcase
    end

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       presp;
        logic       e_rd;
        logic       e_wr;
        logic       e_gv;
        logic [1:0] e_gid;
        logic [3:0] e_resp;
    } vec_t;

    vec_t vtab[$];
    vec_t exp_q[$];
    int   g_q[$];

    function automatic logic [AW-1:0] ad_of(input logic [1:0] p);
        case (p)
            2'd0: return AD0;
            2'd1: return AD1;
            2'd2: return AD2;
            default: return AD3;
        endcase
    endfunction

    function automatic logic [BW-1:0] wd_of(input logic [1:0] p);
        case (p)
            2'd0: return WD0;
            2'd1: return WD1;
            2'd2: return WD2;
            default: return WD3;
        endcase
    endfunction

    task automatic addv(input logic [3:0] rd, input logic [3:0] wr, input logic p,
                        input logic erd, input logic ewr, input logic egv,
                        input logic [1:0] egid, input logic [3:0] eresp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.presp = p;
        v.e_rd = erd; v.e_wr = ewr; v.e_gv = egv; v.e_gid = egid; v.e_resp = eresp;
        vtab.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Compare every observed output against one vector's expectation
    task automatic check_vec(input string nm, input vec_t e, input logic [BW-1:0] erd);
        logic          ok;
        logic [AW-1:0] ea;
        logic [BW-1:0] ew;
        ea = e.e_gv ? ad_of(e.e_gid) : '0;
        ew = e.e_gv ? wd_of(e.e_gid) : '0;
        ok = (m_rd === e.e_rd) && (m_wr === e.e_wr) && (m_gv === e.e_gv) &&
             (m_resp === e.e_resp) && (m_addr === ea) && (m_wdata === ew) &&
             (m_rdata === erd) && (!e.e_gv || (m_gid === e.e_gid));
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got rd=%b wr=%b gv=%b gid=%0d resp=%b addr=%h wd_ok=%b rd_ok=%b, expected rd=%b wr=%b gv=%b gid=%0d resp=%b addr=%h",
                     nm, m_rd, m_wr, m_gv, m_gid, m_resp, m_addr, (m_wdata === ew), (m_rdata === erd),
                     e.e_rd, e.e_wr, e.e_gv, e.e_gid, e.e_resp, ea);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; t_rd = '0; t_wr = '0; t_presp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reactive requesters plus a fixed-latency memory; grants are compared against g_q
    task automatic run_txns(input logic [3:0] want, input int n, input int lat);
        int         done;
        int         bcyc;
        int         cyc;
        int         last_resp;
        int         gexp;
        logic [3:0] drop;
        done = 0; bcyc = 0; cyc = 0; last_resp = -1; gexp = 0; drop = '0;
        while (done < n && cyc < 200) begin
            @(posedge clk); #1;
            t_rd = want & ~drop; t_wr = '0; drop = '0; t_presp = 1'b0;
            @(negedge clk);
            if (m_rd) begin
                if (bcyc == 0) begin
                    gexp = (g_q.size() > 0) ? g_q.pop_front() : -1;
                    chk("grant_id", m_gid, gexp);
                    if (lat == 1 && last_resp >= 0) chk("issue_gap", cyc - last_resp, 3);
                end
                bcyc++;
                if (bcyc >= lat) begin
                    t_presp = 1'b1;
                    #1;
                    chk("req_resp", m_resp, 4'b0001 << gexp);
                    drop      = m_resp;
                    last_resp = cyc;
                    bcyc      = 0;
                    done++;
                end
            end
            cyc++;
        end
        if (done < n) begin
            n_vec++; n_err++;
            $display("FAIL run_txns: completed %0d transactions, expected %0d", done, n);
        end
        @(posedge clk); #1;
        t_presp = 1'b0; t_rd = '0;
        @(posedge clk); @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        reset = 1'b1; t_rd = '0; t_wr = '0; t_presp = 1'b0;
        t_addr   = {AD3, AD2, AD1, AD0};
        t_wdata  = {WD3, WD2, WD1, WD0};
        t_prdata = PRD;

        // Two-port cycle table: rd, wr, presp | rd, wr, gv, gid, resp
        addv(4'h2,4'h0,1'b0, 0,0,0,2'd0,4'h0);   // single-port read, IDLE sample
        addv(4'h2,4'h0,1'b0, 1,0,1,2'd1,4'h0);
        addv(4'h2,4'h0,1'b0, 1,0,1,2'd1,4'h0);
        addv(4'h2,4'h0,1'b0, 1,0,1,2'd1,4'h0);
        addv(4'h2,4'h0,1'b1, 1,0,1,2'd1,4'h2);   // memory done in cycle 4
        addv(4'h0,4'h0,1'b0, 0,0,0,2'd0,4'h0);   // RECOVER
        addv(4'h0,4'h0,1'b0, 0,0,0,2'd0,4'h0);
        addv(4'h1,4'h1,1'b0, 0,0,0,2'd0,4'h0);   // read+write on port 0
        addv(4'h1,4'h1,1'b0, 0,1,1,2'd0,4'h0);
        addv(4'h1,4'h1,1'b1, 0,1,1,2'd0,4'h1);
        addv(4'h0,4'h0,1'b1, 0,0,0,2'd0,4'h0);   // stray resp in RECOVER
        addv(4'h0,4'h0,1'b1, 0,0,0,2'd0,4'h0);   // stray resp in IDLE
        addv(4'h3,4'h0,1'b0, 0,0,0,2'd0,4'h0);   // both ports request
        addv(4'h3,4'h0,1'b0, 1,0,1,2'd0,4'h0);
        addv(4'h3,4'h0,1'b1, 1,0,1,2'd0,4'h1);
        addv(4'h2,4'h0,1'b0, 0,0,0,2'd0,4'h0);
        addv(4'h2,4'h0,1'b0, 0,0,0,2'd0,4'h0);
        addv(4'h2,4'h0,1'b0, 1,0,1,2'd1,4'h0);
        addv(4'h2,4'h0,1'b1, 1,0,1,2'd1,4'h2);
        addv(4'h0,4'h0,1'b0, 0,0,0,2'd0,4'h0);
        addv(4'h1,4'h0,1'b0, 0,0,0,2'd0,4'h0);   // withdrawn mid-BUSY
        addv(4'h1,4'h0,1'b0, 1,0,1,2'd0,4'h0);
        addv(4'h0,4'h0,1'b0, 0,0,1,2'd0,4'h0);
        addv(4'h0,4'h0,1'b0, 0,0,0,2'd0,4'h0);
        addv(4'h1,4'h0,1'b0, 0,0,0,2'd0,4'h0);   // IDLE again after one RECOVER
        addv(4'h1,4'h0,1'b0, 1,0,1,2'd0,4'h0);
        addv(4'h1,4'h0,1'b1, 1,0,1,2'd0,4'h1);
        addv(4'h0,4'h0,1'b0, 0,0,0,2'd0,4'h0);

        // Reset state of every instance
        @(negedge clk); @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            e.rd = '0; e.wr = '0; e.presp = 1'b0;
            e.e_rd = 1'b0; e.e_wr = 1'b0; e.e_gv = 1'b0; e.e_gid = '0; e.e_resp = '0;
            check_vec($sformatf("reset_state%0d", s), e, '0);
            chk($sformatf("reset_gid%0d", s), m_gid, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Two-port table
        sel = 0;
        foreach (vtab[i]) begin
            @(posedge clk); #1;
            t_rd = vtab[i].rd; t_wr = vtab[i].wr; t_presp = vtab[i].presp;
            exp_q.push_back(vtab[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check_vec($sformatf("vec%0d", i), e, PRD);
        end

        // Fixed priority: ports 1 and 3 keep requesting; port 1 always wins
        sel = 1;
        do_reset();
        for (int k = 0; k < 4; k++) g_q.push_back(1);
        run_txns(4'b1010, 4, 2);

        // Round-robin: all ports requesting, memory latency 1
        sel = 2;
        do_reset();
        g_q.push_back(0); g_q.push_back(1); g_q.push_back(2); g_q.push_back(3); g_q.push_back(0);
        run_txns(4'b1111, 5, 1);

        // Reset two cycles into a BUSY read on port 2 (rr_ptr is 1 here)
        @(posedge clk); #1; t_rd = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_strobe", m_rd, 1);
        chk("pre_reset_gid", m_gid, 2);
        #2;
        reset = 1'b1; t_presp = 1'b1;
        #1;
        chk("rst_read", m_rd, 0);
        chk("rst_gv", m_gv, 0);
        chk("rst_resp", m_resp, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", m_rdata, 0);
        @(posedge clk); #1;
        t_presp = 1'b0; t_rd = 4'b1001;
        @(negedge clk);
        reset = 1'b0;
        g_q.push_back(0); g_q.push_back(3);
        run_txns(4'b1001, 2, 2);

        // Withdrawal must leave rr_ptr at 0
        do_reset();
        @(posedge clk); #1; t_rd = 4'b0010;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_busy_gid", m_gid, 1);
        @(posedge clk); #1; t_rd = 4'b0000;
        @(negedge clk);
        chk("wd_strobe", m_rd, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_recover_gv", m_gv, 0);
        g_q.push_back(0);
        run_txns(4'b0101, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
